// File: rtl/alu_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_pkg;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned OP_W    = 3;
    localparam int unsigned FLAG_W  = 4;

    typedef enum logic [OP_W-1:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101
    } operation_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        return op inside {OP_AND, OP_OR, OP_ADD, OP_SUB};
    endfunction

endpackage

// File: rtl/alu_arb_rr.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the
// requester that did not win last time.
module alu_arb_rr
    import alu_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               last_grant,
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        grant = '0;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Arbitrates two requesters onto one ALU, one command in flight, with a
// response timeout and per-requester one-cycle response pulses.
module alu_req_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 200
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    output logic                      alu_valid,
    input  logic                      alu_ready,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [OP_W-1:0]           alu_op,
    input  logic                      alu_rsp_valid,
    input  logic [DATA_W-1:0]         alu_c,
    input  logic [FLAG_W-1:0]         alu_flags,
    input  logic                      alu_err,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_c,
    output logic [FLAG_W-1:0]         rsp_flags,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic                      busy
);

    localparam int unsigned      TMR_W    = $clog2(TIMEOUT_CYC + 1);
    // The timer holds (cycles spent in ISSUE/WAIT - 1); this value marks the
    // last allowed cycle, in which a response still beats the timeout.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    arb_state_t          state_q, state_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                last_grant_q, last_grant_d;
    logic                gnt_q, gnt_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [DATA_W-1:0]   rsp_c_q, rsp_c_d;
    logic [FLAG_W-1:0]   rsp_flags_q, rsp_flags_d;
    logic                rsp_err_q, rsp_err_d;
    logic                rsp_timeout_q, rsp_timeout_d;

    logic [NUM_REQ-1:0]  grant;
    logic                sel;
    logic                accept;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;
    logic [OP_W-1:0]     sel_op;

    alu_arb_rr u_arb (
        .req_valid  (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    assign sel    = grant[1];
    assign accept = (state_q == IDLE) && |(req_valid & grant);
    assign sel_a  = sel ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
    assign sel_b  = sel ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
    assign sel_op = sel ? req_op[2*OP_W-1:OP_W]    : req_op[OP_W-1:0];

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d       = state_q;
        timer_d       = timer_q;
        last_grant_d  = last_grant_q;
        gnt_d         = gnt_q;
        a_d           = a_q;
        b_d           = b_q;
        op_d          = op_q;
        rsp_c_d       = rsp_c_q;
        rsp_flags_d   = rsp_flags_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    gnt_d        = sel;
                    last_grant_d = sel;
                    a_d          = sel_a;
                    b_d          = sel_b;
                    op_d         = sel_op;
                    timer_d      = '0;
                    if (is_legal_op(sel_op)) begin
                        state_d = ISSUE;
                    end else begin
                        state_d       = RESP;
                        rsp_c_d       = '0;
                        rsp_flags_d   = '0;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b0;
                    end
                end
            end
            ISSUE, WAIT: begin
                if (state_q == WAIT && alu_rsp_valid) begin
                    state_d       = RESP;
                    rsp_c_d       = alu_c;
                    rsp_flags_d   = alu_flags;
                    rsp_err_d     = alu_err;
                    rsp_timeout_d = 1'b0;
                end else if (timer_q == TMR_LAST) begin
                    state_d       = RESP;
                    rsp_c_d       = '0;
                    rsp_flags_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                    if (state_q == ISSUE && alu_ready) begin
                        state_d = WAIT;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            last_grant_q  <= 1'b1;
            gnt_q         <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            op_q          <= '0;
            rsp_c_q       <= '0;
            rsp_flags_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            last_grant_q  <= last_grant_d;
            gnt_q         <= gnt_d;
            a_q           <= a_d;
            b_q           <= b_d;
            op_q          <= op_d;
            rsp_c_q       <= rsp_c_d;
            rsp_flags_q   <= rsp_flags_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // req_ready is combinational from req_valid, so it is also gated by reset.
    assign req_ready   = (state_q == IDLE && rst_n) ? grant : '0;
    assign busy        = (state_q != IDLE);
    assign alu_valid   = (state_q == ISSUE);
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_op      = op_q;
    assign rsp_valid   = (state_q == RESP) ? (gnt_q ? 2'b10 : 2'b01) : '0;
    assign rsp_c       = (state_q == RESP) ? rsp_c_q       : '0;
    assign rsp_flags   = (state_q == RESP) ? rsp_flags_q   : '0;
    assign rsp_err     = (state_q == RESP) ? rsp_err_q     : 1'b0;
    assign rsp_timeout = (state_q == RESP) ? rsp_timeout_q : 1'b0;

endmodule

// File: doc/alu_req_arbiter.md
ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 200, cycles allowed from ISSUE entry to ALU response.
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  2  per-requester request valid (bit i = requester i).
REQ-005 req_ready  output  2  per-requester accept; at most one bit high.
REQ-006 req_a  input  64  operand A; requester i at [32i+31:32i].
REQ-007 req_b  input  64  operand B; same packing.
REQ-008 req_op  input  6  operation_t; requester i at [3i+2:3i].
REQ-009 alu_valid  output  1  command to ALU valid.
REQ-010 alu_ready  input  1  ALU accepts command.
REQ-011 alu_a, alu_b  output  32 each  latched operands.
REQ-012 alu_op  output  3  latched operation.
REQ-013 alu_rsp_valid  input  1  ALU result valid, single-cycle pulse.
REQ-014 alu_c  input  32  ALU result.
REQ-015 alu_flags  input  4  ALU flags {carry, overflow, zero, negative}.
REQ-016 alu_err  input  1  ALU error indication.
REQ-017 rsp_valid  output  2  one-hot response pulse to the granted requester.
REQ-018 rsp_c, rsp_flags, rsp_err, rsp_timeout  output  32/4/1/1  response payload.
REQ-019 busy  output  1  high in every state except IDLE.

Function
REQ-020 FSM states IDLE, ISSUE, WAIT, RESP; one request in flight at a time.
REQ-021 IDLE: req_ready[g]=1 combinationally for the grant g among asserted req_valid; acceptance = req_valid[g] & req_ready[g].
REQ-022 Grant: a single valid requester wins; with both valid, the requester not granted last wins (round-robin); last_grant resets to 1, so requester 0 wins the first tie.
REQ-023 On acceptance: latch A, B, op, and g; update last_grant.
REQ-024 Legal ops: AND=3'b000, OR=3'b001, ADD=3'b100, SUB=3'b101.
REQ-025 Illegal op on acceptance: go to RESP directly; no ALU command; rsp_err=1, rsp_c=0, rsp_flags=0, rsp_timeout=0.
REQ-026 Legal op on acceptance: go to ISSUE; clear timer.
REQ-027 ISSUE: alu_valid=1 and alu_a/b/op held stable until alu_ready; then go to WAIT.
REQ-028 WAIT: on alu_rsp_valid, latch alu_c/alu_flags/alu_err; go to RESP; rsp_timeout=0.
REQ-029 Timer increments each cycle in ISSUE and WAIT; at TIMEOUT_CYC without response, go to RESP with rsp_timeout=1, rsp_err=1, rsp_c=0, rsp_flags=0; alu_valid deasserts.
REQ-030 Response arriving in the same cycle as timer expiry: the response wins; no timeout.
REQ-031 RESP: exactly one cycle with rsp_valid[g]=1 and payload valid; then IDLE; req_ready=0 during RESP.
REQ-032 Minimum latency: accept at cycle 0, alu_ready at 1, alu_rsp_valid at 2, rsp_valid at 3.
REQ-033 alu_rsp_valid outside WAIT is ignored, including late responses after a timeout.
REQ-034 rsp payload outputs are 0 whenever rsp_valid=0.

Reset
REQ-035 rst_n low: state=IDLE, timer=0, last_grant=1, and all outputs 0, regardless of the operation in progress.
REQ-036 An in-flight request aborted by reset receives no response.

Structure
REQ-037 operation_t, arb_state_t, and the flag-width constant reside in alu_pkg.
REQ-038 2-way round-robin grant logic is a sub-module, alu_arb_rr (inputs req_valid and last_grant; output one-hot grant).

Verification
REQ-039 Req0 ADD A=32'h7FFFFFFF, B=32'h1; ALU returns C=32'h80000000, flags=4'b0101 after 1 cycle -> rsp_valid=2'b01 at cycle 3 with the same C and flags.
REQ-040 Both valid for 4 consecutive requests after reset -> grant order 0,1,0,1.
REQ-041 Req1 op=3'b010 -> no alu_valid; rsp_valid=2'b10, rsp_err=1, one cycle after acceptance.
REQ-042 TIMEOUT_CYC=8, ALU never responds -> rsp_timeout=1 and rsp_err=1; a later alu_rsp_valid is ignored; the next request is served normally.
REQ-043 rst_n pulled low in WAIT -> outputs 0 immediately; no rsp_valid; busy=0.
REQ-044 alu_ready held low for 5 cycles -> alu_a/b/op stable and alu_valid high throughout.
